pe_os_mac: RTL

Parametrised output-stationary systolic processing element, successor to the single-beat fp32 PE.
- Accumulates a stream of x*w products over a variable-length dot product; the stream is terminated by in_last.
- Forwards operands to neighbouring PEs through a registered, valid-tagged path.
- Returns the finished partial sum through a valid/ready handshake with back-pressure.
- Supports a pipelined integer multiplier, signed or unsigned operation, and optional saturation.

---
 rtl/pe_os_mac.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pe_os_mac.sv
// pe_os_mac: output-stationary systolic MAC PE with operand forwarding, pipelined multiply,
// variable-length accumulation and a valid/ready partial-sum port.
module pe_os_mac #(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 40,
  parameter int MUL_LAT  = 2,
  parameter int K_MAX    = 256,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] w_i,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic              signed_mode,
  output logic              stall,
  output logic [DATA_W-1:0] x_o,
  output logic [DATA_W-1:0] w_o,
  output logic              valid_o,
  output logic              last_o,
  output logic [ACC_W-1:0]  psum_o,
  output logic              psum_valid,
  input  logic              psum_ready,
  output logic              sat,
  output logic              len_err
);
  localparam int PW    = 2 * DATA_W;
  localparam int EW    = (ACC_W > PW ? ACC_W : PW) + 2;
  localparam int CNT_W = $clog2(K_MAX + 1);
  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, SEND} state_t;
  state_t            state, state_n;
  logic [ACC_W-1:0]  acc, acc_add, clamp;
  logic              sat_r, mode_r, accept, start, last_eff, eff_mode, ovf, busy;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [PW-1:0]     pp [MUL_LAT];
  logic [MUL_LAT-1:0] pv;
  logic [PW-1:0]     prod;
  logic [EW-1:0]     sum;

  assign stall      = (state == FLUSH) || (state == SEND && !psum_ready);
  assign accept     = in_valid && !stall;
  assign start      = accept && (state == IDLE || state == SEND);
  assign eff_mode   = start ? signed_mode : mode_r;
  assign cnt_nxt    = start ? CNT_W'(1) : cnt + CNT_W'(1);
  assign last_eff   = in_last || (cnt_nxt == CNT_W'(K_MAX));
  assign busy       = |pv;
  assign psum_valid = (state == SEND);
  assign psum_o     = acc;
  assign sat        = sat_r;

  // Extending both operands by the mode bit lets one multiplier serve signed and unsigned.
  assign prod = {{DATA_W{eff_mode & x_i[DATA_W-1]}}, x_i} * {{DATA_W{eff_mode & w_i[DATA_W-1]}}, w_i};
  // Wide sum so overflow is visible even when the product is wider than the accumulator.
  assign sum = {{(EW-ACC_W){mode_r & acc[ACC_W-1]}}, acc}
             + {{(EW-PW){mode_r & pp[MUL_LAT-1][PW-1]}}, pp[MUL_LAT-1]};
  assign ovf = mode_r ? !(&sum[EW-1:ACC_W-1] || ~|sum[EW-1:ACC_W-1]) : |sum[EW-1:ACC_W];
  assign clamp   = mode_r ? {sum[EW-1], {(ACC_W-1){~sum[EW-1]}}} : '1;
  assign acc_add = (ovf && SATURATE != 0) ? clamp : sum[ACC_W-1:0];

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = last_eff ? FLUSH : ACCUM;
      ACCUM:   if (accept && last_eff) state_n = FLUSH;
      FLUSH:   if (!busy) state_n = SEND;
      SEND:    if (psum_ready) state_n = accept ? (last_eff ? FLUSH : ACCUM) : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else state <= state_n;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x_o     <= '0;
      w_o     <= '0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end else begin
      valid_o <= accept;
      x_o     <= accept ? x_i : x_o;
      w_o     <= accept ? w_i : w_o;
      last_o  <= accept ? in_last : last_o;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pv <= '0;
      for (int i = 0; i < MUL_LAT; i++) pp[i] <= '0;
    end else begin
      pv[0] <= accept;
      pp[0] <= accept ? prod : pp[0];
      for (int i = 1; i < MUL_LAT; i++) begin
        pv[i] <= pv[i-1];
        pp[i] <= pp[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc     <= '0;
      sat_r   <= 1'b0;
      mode_r  <= 1'b0;
      cnt     <= '0;
      len_err <= 1'b0;
    end else begin
      acc     <= start ? '0 : (pv[MUL_LAT-1] ? acc_add : acc);
      sat_r   <= start ? 1'b0 : (sat_r | (pv[MUL_LAT-1] & ovf));
      mode_r  <= eff_mode;
      cnt     <= accept ? cnt_nxt : cnt;
      len_err <= len_err | (accept && !in_last && cnt_nxt == CNT_W'(K_MAX));
    end
  end
endmodule
